// File: rtl/braille_wb_pkg.sv
// Shared constants for the braille Wishbone responder: register map, bit positions, ID word.
package braille_wb_pkg;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCmd    = 2'd2;
  localparam logic [1:0] RegId     = 2'd3;

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlIrqEn = 1;
  localparam int unsigned CtrlClr   = 2;

  localparam int unsigned StatEmpty = 8;
  localparam int unsigned StatFull  = 9;
  localparam int unsigned StatOvf   = 10;
  localparam int unsigned StatDone  = 11;

  localparam int unsigned LevelW = 5;

  localparam logic [31:0] IdValue = 32'hB7A1_0001;

  function automatic logic [31:0] status_word(input logic [LevelW-1:0] level,
                                              input logic empty, input logic full,
                                              input logic ovf, input logic done);
    logic [31:0] w;
    w = '0;
    w[LevelW-1:0] = level;
    w[StatEmpty]  = empty;
    w[StatFull]   = full;
    w[StatOvf]    = ovf;
    w[StatDone]   = done;
    return w;
  endfunction

endpackage

// File: rtl/braille_cmd_fifo.sv
// Synchronous command FIFO with clear; Depth must be a power of two so pointers wrap naturally.
module braille_cmd_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clr_i,
  input  logic                                push_i,
  input  logic [Width-1:0]                    data_i,
  input  logic                                pop_i,
  output logic [Width-1:0]                    data_o,
  output logic [braille_wb_pkg::LevelW-1:0]   level_o,
  output logic                                full_o,
  output logic                                empty_o
);
  import braille_wb_pkg::*;

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      level_q <= level_q + LevelW'(do_push) - LevelW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/braille_wb_responder.sv
// Wishbone classic slave feeding a command FIFO to a braille driver.
// Optional interrupt logic enabled by defining BRAILLE_WB_IRQ_EN.
module braille_wb_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cmd_valid_o,
  output logic [31:0] cmd_data_o,
  input  logic        cmd_ready_i,
  output logic        drv_enable_o,
  output logic        irq_o
);
  import braille_wb_pkg::*;

  logic              ack_q, en_q, irq_en_q, ovf_q, done_q;
  logic [31:0]       dat_q, dat_d, rdata;
  logic              hit, req, wr, wr_ctrl, wr_stat, wr_cmd, clr, pop;
  logic              ovf_set, done_set;
  logic [1:0]        idx;
  logic [31:0]       head;
  logic [LevelW-1:0] level;
  logic              full, empty;
  logic              unused_ok;

  assign unused_ok = ^{wbs_sel_i[3:2], wbs_adr_i[1:0]};

  assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign idx = wbs_adr_i[3:2];
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q;

  // Writes commit in the ack cycle; classic masters hold the request until acked.
  assign wr      = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i & hit;
  assign wr_ctrl = wr & (idx == RegCtrl) & wbs_sel_i[0];
  assign wr_stat = wr & (idx == RegStatus) & wbs_sel_i[1];
  assign wr_cmd  = wr & (idx == RegCmd);
  assign clr     = wr_ctrl & wbs_dat_i[CtrlClr];

  assign cmd_valid_o  = en_q & ~empty;
  assign cmd_data_o   = empty ? '0 : head;
  assign pop          = cmd_valid_o & cmd_ready_i;
  assign drv_enable_o = en_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;

  assign ovf_set  = wr_cmd & full & ~pop;
  assign done_set = pop & (level == LevelW'(1)) & ~wr_cmd & ~clr;

  braille_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (clr),
    .push_i  (wr_cmd),
    .data_i  (wbs_dat_i),
    .pop_i   (pop),
    .data_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rdata = '0;
    unique case (idx)
      RegCtrl: begin
        rdata[CtrlEn]    = en_q;
        rdata[CtrlIrqEn] = irq_en_q;
      end
      RegStatus: rdata = status_word(level, empty, full, ovf_q, done_q);
      RegCmd:    rdata = '0;
      RegId:     rdata = IdValue;
      default:   rdata = '0;
    endcase
    dat_d = (req & ~wbs_we_i & hit) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      en_q   <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= dat_d;
      if (wr_ctrl) en_q <= wbs_dat_i[CtrlEn];
      // A new event wins over a same-cycle clear so it is never lost.
      ovf_q  <= ovf_set  | (ovf_q  & ~(wr_stat & wbs_dat_i[StatOvf]));
      done_q <= done_set | (done_q & ~(wr_stat & wbs_dat_i[StatDone]));
    end
  end

`ifdef BRAILLE_WB_IRQ_EN
  logic irq_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wbs_dat_i[CtrlIrqEn];
      irq_q <= irq_en_q & (ovf_q | done_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq_o    = 1'b0;
`endif

endmodule

// File: doc/braille_wb_responder.md
BRAILLE_WB_RESPONDER -- requirements
Module: braille_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; bits [3:0] ignored.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, command FIFO depth; power of two, 2..16.
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port wb_rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-006 SHALL have port wbs_sel_i  input  4  byte-lane select.
REQ-007 SHALL have ports wbs_adr_i, wbs_dat_i  input  32 each  address, write data.
REQ-008 SHALL have port wbs_ack_o  output  1  transfer acknowledge.
REQ-009 SHALL have port wbs_dat_o  output  32  read data.
REQ-010 SHALL have port cmd_valid_o  output  1  command word available to braille driver.
REQ-011 SHALL have port cmd_data_o  output  32  command word (FIFO head).
REQ-012 SHALL have port cmd_ready_i  input  1  driver accepts command.
REQ-013 SHALL have port drv_enable_o  output  1  driver enable (CTRL.EN).
REQ-014 SHALL have port irq_o  output  1  registered interrupt.

Function
REQ-015 SHALL treat an access as a hit when wbs_adr_i[31:4]==BASE_ADDR[31:4]; register index = wbs_adr_i[3:2]: 0 CTRL, 1 STATUS, 2 CMD, 3 ID.
REQ-016 SHALL assert wbs_ack_o for exactly one cycle, one cycle after cyc&stb sampled high with ack low; back-to-back accesses ack every other cycle.
REQ-017 SHALL ack non-hit accesses identically; reads return 0, writes have no effect.
REQ-018 SHALL present read data on wbs_dat_o in the ack cycle; 0 when ack low.
REQ-019 CTRL: bit0 EN, bit1 IRQ_EN, bit2 CLR (write-1 self-clearing, reads 0); byte lane 0 honoured only when wbs_sel_i[0]=1.
REQ-020 STATUS: [4:0] level, [8] empty, [9] full, [10] OVF sticky, [11] DONE sticky; OVF/DONE write-1-to-clear via lane 1.
REQ-021 CMD write SHALL push wbs_dat_i (all 32 bits, sel ignored) in the ack cycle; CMD reads return 0.
REQ-022 ID SHALL read constant 32'hB7A1_0001.
REQ-023 Push when full with no simultaneous pop SHALL drop data, set OVF; push and pop in same cycle when full SHALL both succeed, level unchanged.
REQ-024 cmd_valid_o = EN & ~empty; cmd_data_o = FIFO head; pop when cmd_valid_o & cmd_ready_i.
REQ-025 cmd_valid_o SHALL stay high until accepted, except clearing EN or CLR deasserts it next cycle.
REQ-026 DONE SHALL set on the cycle a pop makes level 1->0 with no concurrent push.
REQ-027 CLR SHALL empty FIFO the cycle after write; CLR wins over a same-cycle push or pop; CLR does not set DONE.
REQ-028 irq_o SHALL be registered: IRQ_EN & (OVF | DONE), one cycle after the flag sets.

Reset
REQ-029 On wb_rst_ni low, asynchronously: wbs_ack_o=0, wbs_dat_o=0, cmd_valid_o=0, cmd_data_o=0, drv_enable_o=0, irq_o=0, CTRL=0, OVF=DONE=0, FIFO empty.
REQ-030 Reset mid-transfer SHALL abort it with no ack; release deassertion is synchronous to wb_clk_i via external synchroniser.

Configuration
REQ-031 Macro BRAILLE_WB_IRQ_EN defined: irq behaviour per REQ-028; undefined: irq_o tied 0, CTRL.IRQ_EN not writable and reads 0, OVF/DONE flags still function.

Structure
REQ-032 Package braille_wb_pkg SHALL hold register index constants, CTRL/STATUS bit positions, ID constant.
REQ-033 Sub-module braille_cmd_fifo (synchronous FIFO, push/pop/clear/level/full/empty) SHALL hold FIFO storage.

Verification
REQ-034 Reset then read ID at BASE_ADDR+0xC -> ack one cycle after stb, data 32'hB7A1_0001; STATUS reads 32'h0000_0100.
REQ-035 EN=1, cmd_ready_i=0, push 9 words (depth 8) -> STATUS level 8, full=1, OVF=1; words 1..8 emerge in order once ready=1.
REQ-036 Full FIFO, ready=1, CMD write in pop cycle -> level stays 8, OVF stays 0.
REQ-037 IRQ_EN=1, push 1 word, ready=1 -> DONE=1, irq_o high one cycle later; write STATUS 32'h0000_0800 -> irq_o low next cycle.
REQ-038 3 words queued, write CTRL 32'h5 -> level 0 next cycle, cmd_valid_o low, DONE=0.
REQ-039 Access at BASE_ADDR+0x20 write then read -> both acked, read returns 0, no register changes.
